cache_set_assoc_ctrl: RTL and testbench
=======================================

Name: cache_set_assoc_ctrl

Overview:
Parametrised N-way set-associative, write-back, write-allocate cache with integrated controller.
- Storage layout matches the existing design: tag, index and offset fields taken from the address word; per-way valid, dirty and age state.
- Adds a request/response handshake, miss handling with line fill, and dirty-victim write-back over a word-wide memory port.
- Sits between the CPU datapath and main memory as a self-contained cache subsystem.

Parameters:
ADDR_W, 32, address word width
INDEX_W, 7, set index width (SETS = 2**INDEX_W)
OFFSET_W, 3, word offset within line (BLOCK = 2**OFFSET_W words)
WORD_W, 8, data word width
WAYS, 4, associativity; power of two, >=2
TAG_W, ADDR_W-INDEX_W-OFFSET_W, derived; do not override

Ports:
clk  in  1  clock; all logic on rising edge
rst_b  in  1  reset, synchronous, active-high
req_valid  in  1  CPU request present
req_ready  out  1  controller can accept a request (high only in IDLE)
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  request address {tag,index,offset}
req_wdata  in  WORD_W  write data
resp_valid  out  1  one-cycle pulse: request completed
resp_rdata  out  WORD_W  read data (held until next resp_valid)
resp_hit  out  1  1 = request hit; valid with resp_valid
mem_valid  out  1  memory transfer request
mem_write  out  1  1 = write-back word, 0 = fill read
mem_addr  out  ADDR_W  word address of transfer
mem_wdata  out  WORD_W  write-back data
mem_ready  in  1  memory accepts the transfer; for reads, mem_rdata is valid this cycle
mem_rdata  in  WORD_W  fill data

Behaviour:
- Reset (rst_b=1 at an edge):
  - State goes to IDLE; all valid and dirty bits cleared.
  - Ages in every set initialised to way index (way w age = w).
  - Outputs: req_ready=1, resp_valid=0, resp_hit=0, resp_rdata=0, mem_valid=0, mem_write=0, mem_addr=0, mem_wdata=0.
  - Data array contents need no reset.
- Request accept: req_valid & req_ready at an edge latches write, addr and wdata, then goes to LOOKUP.
  - req_valid while req_ready=0 is ignored; no queueing.
- LOOKUP (1 cycle): compare tag against all valid ways of the indexed set.
  - Hit -> RESP.
  - Miss: choose victim, then go to WB if victim is valid & dirty, else FILL.
- Victim selection: lowest-index invalid way; if all ways are valid, the way with age WAYS-1.
- WB: BLOCK transfers, counter 0..BLOCK-1.
  - mem_write=1, mem_addr={victim tag,index,counter}, mem_wdata=victim word[counter].
  - mem_valid stays asserted, with fields stable, until mem_ready; counter advances on each mem_ready.
  - After the last word: clear the dirty bit, go to FILL.
- FILL: same handshake with mem_write=0 and mem_addr={req tag,index,counter}.
  - Each mem_ready writes mem_rdata into victim word[counter].
  - After the last word: tag written, valid=1, dirty=0, go to RESP.
- RESP (1 cycle):
  - Read: resp_rdata = line word[offset].
  - Write: line word[offset] = wdata, dirty=1.
  - resp_valid pulses; resp_hit = hit flag latched in LOOKUP.
  - LRU update (below); return to IDLE.
- Latency: a hit gives resp_valid on the 2nd edge after acceptance. A miss adds BLOCK mem handshakes, plus BLOCK more if the victim is dirty.
- LRU update on the accessed way a (old age A):
  - a's age becomes 0.
  - Every way whose age < A increments; others unchanged.
  - Ages in a set stay a permutation of 0..WAYS-1.
- mem_ready while mem_valid=0 is ignored.
- Reset mid-operation (any state) aborts immediately:
  - mem_valid drops at that edge.
  - Partially filled line is not validated, since all valid bits are cleared.
  - No resp_valid is issued for the aborted request.

Decomposition:
- Package cache_pkg: FSM state enum (IDLE, LOOKUP, WB, FILL, RESP), derived-width helper functions (TAG_W, BLOCK, AGE_W = log2 WAYS).
- Sub-module cache_lru_update: combinational per-set age update and victim select (inputs: ages, valid vector, accessed way; outputs: new ages, victim index).

Test Plan:
Defaults throughout; memory model returns mem_rdata = mem_addr[7:0] after a 1-cycle ready delay.
1. Reset -> req_ready=1, mem_valid=0, resp_valid=0. Then read 0x00000123 -> resp_hit=0, 8 mem reads at 0x120..0x127, resp_rdata=0x23.
2. After test 1, read 0x00000125 -> resp_hit=1, resp_valid exactly 2 edges after accept, resp_rdata=0x25, no mem_valid.
3. Write 0x00000125 data 0x5A (hit) -> resp_hit=1. Then read 0x00000125 -> 0x5A.
4. Read 0x520, 0x920, 0xD20 (same index 0x24, tags 1..3) -> three clean fills into ways 1..3.
   - Then read 0x1120 -> 8 write-back transfers to 0x120..0x127 (word 5 = 0x5A), then fill 0x1120..0x1127, resp_rdata=0x20.
5. Assert rst_b during the 4th FILL word of a miss -> mem_valid=0 next cycle, no resp_valid. Re-read the same address -> miss again (resp_hit=0).
6. Hold req_valid high with back-to-back requests and mem_ready stalled 5 cycles -> req_ready=0 throughout, mem_addr and mem_valid stable while stalled, requests accepted only in IDLE.

Source files
------------

// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Shared types and width helpers for the set-associative cache
//               controller and its LRU sub-block.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

  // Controller states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    WB     = 3'd2,
    FILL   = 3'd3,
    RESP   = 3'd4
  } state_t;

  // Tag width left over once index and offset are carved out of the address
  function automatic int calc_tag_w(input int addr_w, input int index_w, input int offset_w);
    return addr_w - index_w - offset_w;
  endfunction

  // Words per cache line
  function automatic int calc_block(input int offset_w);
    return 1 << offset_w;
  endfunction

  // Bits needed for a per-way age (also used as the way-index width)
  function automatic int calc_age_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_lru_update.sv
`default_nettype none
// ============================================================================
// Module      : cache_lru_update
// Description : Combinational age update for one set (accessed way becomes
//               youngest, younger ways age by one) and victim selection
//               (lowest invalid way, else the oldest way).
// Revision    : 1.0 - initial release
// ============================================================================
module cache_lru_update #(
  parameter int WAYS  = 4,
  parameter int AGE_W = 2
) (
  input  logic [WAYS-1:0][AGE_W-1:0] ages,
  input  logic [WAYS-1:0]            valid,
  input  logic [AGE_W-1:0]           access_way,
  output logic [WAYS-1:0][AGE_W-1:0] new_ages,
  output logic [AGE_W-1:0]           victim
);

  logic [AGE_W-1:0] access_age;

  assign access_age = ages[access_way];

  // Ages remain a permutation: only ways younger than the accessed one move
  for (genvar w = 0; w < WAYS; w++) begin : g_age
    assign new_ages[w] = (AGE_W'(w) == access_way) ? '0 :
                         (ages[w] < access_age)     ? ages[w] + AGE_W'(1) :
                                                      ages[w];
  end

  // Victim: first empty way wins; otherwise evict the way at maximum age
  always_comb begin
    logic found;
    victim = '0;
    found  = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !valid[w]) begin
        victim = AGE_W'(w);
        found  = 1'b1;
      end
    end
    if (!found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (ages[w] == AGE_W'(WAYS - 1)) begin
          victim = AGE_W'(w);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cache_set_assoc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cache_set_assoc_ctrl
// Description : N-way set-associative, write-back, write-allocate cache with
//               request/response CPU port and word-wide memory port for line
//               fill and dirty-victim write-back.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_set_assoc_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int INDEX_W  = 7,
  parameter int OFFSET_W = 3,
  parameter int WORD_W   = 8,
  parameter int WAYS     = 4
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_hit,
  output logic              mem_valid,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [WORD_W-1:0] mem_rdata
);

  localparam int TAG_W      = calc_tag_w(ADDR_W, INDEX_W, OFFSET_W);
  localparam int SETS       = 1 << INDEX_W;
  localparam int BLOCK      = calc_block(OFFSET_W);
  localparam int AGE_W      = calc_age_w(WAYS);
  localparam int LINE_WORDS = SETS * BLOCK;

  state_t state, next_state;

  // Latched request and per-miss bookkeeping
  logic                lat_write;
  logic [ADDR_W-1:0]   lat_addr;
  logic [WORD_W-1:0]   lat_wdata;
  logic                hit_flag;
  logic [AGE_W-1:0]    way_sel;
  logic [OFFSET_W-1:0] cnt;

  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  set_idx;
  logic [OFFSET_W-1:0] word_off;
  logic                last_word;

  // Storage: data and tags need no reset; state bits are packed for a flat clear
  logic [WORD_W-1:0]                      data_arr [WAYS][LINE_WORDS];
  logic [TAG_W-1:0]                       tag_arr  [SETS][WAYS];
  logic [SETS-1:0][WAYS-1:0]              valid_arr;
  logic [SETS-1:0][WAYS-1:0]              dirty_arr;
  logic [SETS-1:0][WAYS-1:0][AGE_W-1:0]   age_arr;
  logic [WAYS-1:0][AGE_W-1:0]             age_init;

  logic [WAYS-1:0]            set_valid;
  logic [WAYS-1:0]            set_dirty;
  logic [WAYS-1:0][AGE_W-1:0] set_ages;
  logic [WAYS-1:0][AGE_W-1:0] upd_ages;
  logic [AGE_W-1:0]           victim_way;
  logic                       victim_dirty;

  logic                         hit;
  logic [AGE_W-1:0]             hit_way;
  logic [INDEX_W+OFFSET_W-1:0]  word_addr;
  logic [WORD_W-1:0]            rd_word;
  logic                         arr_we;
  logic [WORD_W-1:0]            arr_wdata;

  assign req_tag   = lat_addr[ADDR_W-1 -: TAG_W];
  assign set_idx   = lat_addr[OFFSET_W +: INDEX_W];
  assign word_off  = lat_addr[OFFSET_W-1:0];
  assign last_word = &cnt;

  for (genvar w = 0; w < WAYS; w++) begin : g_age_init
    assign age_init[w] = AGE_W'(w);
  end

  assign set_valid    = valid_arr[set_idx];
  assign set_dirty    = dirty_arr[set_idx];
  assign set_ages     = age_arr[set_idx];
  assign victim_dirty = set_valid[victim_way] & set_dirty[victim_way];

  // Tag compare across the indexed set; lowest matching way reported
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (set_valid[w] && (tag_arr[set_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = AGE_W'(w);
      end
    end
  end

  cache_lru_update #(
    .WAYS  (WAYS),
    .AGE_W (AGE_W)
  ) u_lru (
    .ages       (set_ages),
    .valid      (set_valid),
    .access_way (way_sel),
    .new_ages   (upd_ages),
    .victim     (victim_way)
  );

  // Memory transfers walk the line with cnt; the response uses the request offset
  assign word_addr = {set_idx, ((state == WB) || (state == FILL)) ? cnt : word_off};
  assign rd_word   = data_arr[way_sel][word_addr];
  assign arr_we    = !rst_b && (((state == FILL) && mem_ready) || ((state == RESP) && lat_write));
  assign arr_wdata = (state == FILL) ? mem_rdata : lat_wdata;

  // Data and tag arrays: fill words, CPU write data, and tag on line completion
  always_ff @(posedge clk) begin
    if (arr_we) begin
      data_arr[way_sel][word_addr] <= arr_wdata;
    end
    if (!rst_b && (state == FILL) && mem_ready && last_word) begin
      tag_arr[set_idx][way_sel] <= req_tag;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst_b) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and memory-port/handshake outputs
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    mem_valid  = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) next_state = LOOKUP;
      end
      LOOKUP: begin
        if (hit)               next_state = RESP;
        else if (victim_dirty) next_state = WB;
        else                   next_state = FILL;
      end
      WB: begin
        mem_valid = 1'b1;
        mem_write = 1'b1;
        mem_addr  = {tag_arr[set_idx][way_sel], set_idx, cnt};
        mem_wdata = rd_word;
        if (mem_ready && last_word) next_state = FILL;
      end
      FILL: begin
        mem_valid = 1'b1;
        mem_addr  = {req_tag, set_idx, cnt};
        if (mem_ready && last_word) next_state = RESP;
      end
      RESP: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Request latch, miss bookkeeping, line state bits, LRU and response outputs
  always_ff @(posedge clk) begin
    if (rst_b) begin
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      hit_flag   <= 1'b0;
      way_sel    <= '0;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_hit   <= 1'b0;
      valid_arr  <= '0;
      dirty_arr  <= '0;
      age_arr    <= {SETS{age_init}};
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
          end
        end
        LOOKUP: begin
          hit_flag <= hit;
          way_sel  <= hit ? hit_way : victim_way;
          cnt      <= '0;
        end
        WB: begin
          if (mem_ready) begin
            cnt <= cnt + 1'b1;
            if (last_word) dirty_arr[set_idx][way_sel] <= 1'b0;
          end
        end
        FILL: begin
          if (mem_ready) begin
            cnt <= cnt + 1'b1;
            if (last_word) begin
              valid_arr[set_idx][way_sel] <= 1'b1;
              dirty_arr[set_idx][way_sel] <= 1'b0;
            end
          end
        end
        RESP: begin
          resp_valid       <= 1'b1;
          resp_hit         <= hit_flag;
          age_arr[set_idx] <= upd_ages;
          if (lat_write) dirty_arr[set_idx][way_sel] <= 1'b1;
          else           resp_rdata <= rd_word;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_set_assoc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_set_assoc_ctrl
// Description : Directed and randomized checks of the cache controller against
//               a recency-timestamp cache model and an addr[7:0] memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_set_assoc_ctrl;

  localparam int SETS  = 128;
  localparam int WAYS  = 4;
  localparam int BLOCK = 8;
  localparam int TAG_W = 22;

  logic        clk;
  logic        rst_b;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr;
  logic [7:0]  req_wdata;
  logic        resp_valid, resp_hit;
  logic [7:0]  resp_rdata;
  logic        mem_valid, mem_write, mem_ready;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  cache_set_assoc_ctrl dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_hit   (resp_hit),
    .mem_valid  (mem_valid),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic        w;
    logic [31:0] a;
    logic [7:0]  d;
  } xfer_t;

  xfer_t obs_q[$];
  xfer_t exp_q[$];

  // Cache model: per-way contents plus a last-use timestamp for LRU
  bit          m_valid [SETS][WAYS];
  bit          m_dirty [SETS][WAYS];
  logic [21:0] m_tag   [SETS][WAYS];
  logic [7:0]  m_data  [SETS][WAYS][BLOCK];
  int          m_stamp [SETS][WAYS];
  int          m_clock;

  bit g_ready_ok, g_stable_ok, g_spurious;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
        m_stamp[s][w] = -w;
      end
    m_clock = 0;
  endtask

  task automatic model_access(input logic wr, input logic [31:0] addr, input logic [7:0] wd,
                              output logic exp_hit, output logic [7:0] exp_rd);
    logic [6:0]  idx = addr[9:3];
    logic [21:0] t   = addr[31:10];
    int          s   = int'(addr[9:3]);
    int          off = int'(addr[2:0]);
    int          way = -1;
    logic [31:0] fa;
    exp_q.delete();
    for (int w = 0; w < WAYS; w++)
      if (m_valid[s][w] && m_tag[s][w] == t) way = w;
    exp_hit = (way >= 0);
    if (way < 0) begin
      for (int w = WAYS - 1; w >= 0; w--)
        if (!m_valid[s][w]) way = w;
      if (way < 0) begin
        way = 0;
        for (int w = 1; w < WAYS; w++)
          if (m_stamp[s][w] < m_stamp[s][way]) way = w;
      end
      if (m_valid[s][way] && m_dirty[s][way])
        for (int k = 0; k < BLOCK; k++)
          exp_q.push_back({1'b1, m_tag[s][way], idx, 3'(k), m_data[s][way][k]});
      for (int k = 0; k < BLOCK; k++) begin
        fa = {t, idx, 3'(k)};
        exp_q.push_back({1'b0, fa, 8'h00});
        m_data[s][way][k] = fa[7:0];
      end
      m_tag[s][way]   = t;
      m_valid[s][way] = 1'b1;
      m_dirty[s][way] = 1'b0;
    end
    exp_rd = 8'h00;
    if (wr) begin
      m_data[s][way][off] = wd;
      m_dirty[s][way]     = 1'b1;
    end else begin
      exp_rd = m_data[s][way][off];
    end
    m_clock++;
    m_stamp[s][way] = m_clock;
  endtask

  // Drives one request from a negedge, services memory, returns at the resp_valid negedge
  task automatic run_req(input logic wr, input logic [31:0] addr, input logic [7:0] wd,
                         input int stall, input bit hold, input int abort_at,
                         output logic got_hit, output logic [7:0] got_rd,
                         output int edges, output bit done);
    int    guard = 0;
    int    wait_c = 0;
    int    fills = 0;
    bit    no_resp;
    xfer_t cur, held;
    done = 1'b0; edges = 0; got_hit = 1'b0; got_rd = 8'h00;
    g_ready_ok = 1'b1; g_stable_ok = 1'b1;
    held = '0;
    obs_q.delete();
    while (!req_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      check("accept_timeout", req_ready, 1);
      return;
    end
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
    while (edges < 400) begin
      if (resp_valid) begin
        done    = 1'b1;
        got_hit = resp_hit;
        got_rd  = resp_rdata;
        break;
      end
      if (req_ready) g_ready_ok = 1'b0;
      mem_ready = 1'b0;
      if (mem_valid) begin
        cur = {mem_write, mem_addr, mem_wdata};
        if (abort_at >= 0 && !mem_write && fills == abort_at) begin
          check("t5.fills_before_abort", fills, 3);
          rst_b = 1'b1; req_valid = 1'b0;
          @(posedge clk);
          @(negedge clk);
          check("t5.mem_valid_after_reset", mem_valid, 0);
          check("t5.resp_valid_after_reset", resp_valid, 0);
          check("t5.req_ready_after_reset", req_ready, 1);
          rst_b = 1'b0;
          no_resp = 1'b1;
          repeat (6) begin
            @(posedge clk);
            @(negedge clk);
            if (resp_valid || mem_valid) no_resp = 1'b0;
          end
          check("t5.quiet_after_abort", no_resp, 1);
          return;
        end
        if (wait_c == 0) held = cur;
        else if (cur !== held) g_stable_ok = 1'b0;
        if (wait_c >= stall) begin
          mem_ready = 1'b1;
          mem_rdata = mem_addr[7:0];
          obs_q.push_back({mem_write, mem_addr, mem_write ? mem_wdata : 8'h00});
          if (!mem_write) fills++;
          wait_c = 0;
        end else begin
          wait_c++;
        end
      end else begin
        mem_ready = g_spurious && ($urandom_range(0, 3) == 0);
        mem_rdata = 8'($urandom);
      end
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    mem_ready = 1'b0;
    if (!done) check("resp_timeout", resp_valid, 1);
  endtask

  // Model first, then drive, then compare hit, data and every memory transfer
  task automatic do_op(input string tag, input logic wr, input logic [31:0] addr, input logic [7:0] wd,
                       input int stall, input bit hold,
                       output logic got_hit, output logic [7:0] got_rd, output int edges);
    logic exp_hit;
    logic [7:0] exp_rd;
    bit done;
    int n;
    model_access(wr, addr, wd, exp_hit, exp_rd);
    run_req(wr, addr, wd, stall, hold, -1, got_hit, got_rd, edges, done);
    if (done) begin
      check({tag, ".hit"}, got_hit, exp_hit);
      if (!wr) check({tag, ".rdata"}, got_rd, exp_rd);
      check({tag, ".xfer_count"}, obs_q.size(), exp_q.size());
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
        check($sformatf("%s.xfer%0d", tag, i), obs_q[i], exp_q[i]);
    end
  endtask

  initial begin
    logic       h;
    logic [7:0] rd;
    int         ed;
    bit         dn;
    logic       wr;
    logic [6:0] idx;
    logic [31:0] a;

    rst_b = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0; g_spurious = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.req_ready", req_ready, 1);
    check("reset.mem_valid", mem_valid, 0);
    check("reset.resp_valid", resp_valid, 0);
    check("reset.resp_rdata", resp_rdata, 0);
    check("reset.resp_hit", resp_hit, 0);
    check("reset.mem_fields", {mem_write, mem_addr, mem_wdata}, 0);
    rst_b = 1'b0;
    @(negedge clk);

    // 1: cold miss fill
    do_op("t1", 1'b0, 32'h123, 8'h00, 1, 1'b0, h, rd, ed);
    check("t1.rdata_const", rd, 8'h23);
    if (obs_q.size() > 0) check("t1.first_fill_addr", obs_q[0].a, 32'h120);

    // 2: hit latency and pulse width
    do_op("t2", 1'b0, 32'h125, 8'h00, 1, 1'b0, h, rd, ed);
    check("t2.latency", ed, 2);
    check("t2.rdata_const", rd, 8'h25);
    @(negedge clk);
    check("t2.resp_pulse", resp_valid, 0);
    check("t2.rdata_held", resp_rdata, 8'h25);

    // 3: write hit then read back
    do_op("t3w", 1'b1, 32'h125, 8'h5A, 1, 1'b0, h, rd, ed);
    check("t3w.hit_const", h, 1);
    do_op("t3r", 1'b0, 32'h125, 8'h00, 1, 1'b0, h, rd, ed);
    check("t3r.rdata_const", rd, 8'h5A);

    // 4: fill remaining ways, then evict the dirty LRU line
    do_op("t4a", 1'b0, 32'h520, 8'h00, 1, 1'b0, h, rd, ed);
    do_op("t4b", 1'b0, 32'h920, 8'h00, 1, 1'b0, h, rd, ed);
    do_op("t4c", 1'b0, 32'hD20, 8'h00, 1, 1'b0, h, rd, ed);
    do_op("t4d", 1'b0, 32'h1120, 8'h00, 1, 1'b0, h, rd, ed);
    check("t4d.rdata_const", rd, 8'h20);
    check("t4d.xfer_total", obs_q.size(), 16);
    if (obs_q.size() > 5) check("t4d.wb_word5", obs_q[5], {1'b1, 32'h125, 8'h5A});

    // 5: reset during the 4th fill word, then the line must miss again
    run_req(1'b0, 32'h2345, 8'h00, 1, 1'b0, 3, h, rd, ed, dn);
    check("t5.aborted_no_resp", dn, 0);
    model_reset();
    do_op("t5r", 1'b0, 32'h2345, 8'h00, 1, 1'b0, h, rd, ed);
    check("t5r.hit_const", h, 0);

    // 6: req_valid held across back-to-back requests with 5-cycle memory stalls
    do_op("t6a", 1'b1, 32'h3040, 8'h77, 5, 1'b1, h, rd, ed);
    check("t6a.ready_low", g_ready_ok, 1);
    check("t6a.mem_stable", g_stable_ok, 1);
    do_op("t6b", 1'b0, 32'h7040, 8'h00, 5, 1'b1, h, rd, ed);
    check("t6b.ready_low", g_ready_ok, 1);
    check("t6b.mem_stable", g_stable_ok, 1);
    do_op("t6c", 1'b0, 32'h3040, 8'h00, 5, 1'b1, h, rd, ed);
    check("t6c.ready_low", g_ready_ok, 1);
    check("t6c.rdata_const", rd, 8'h77);
    req_valid = 1'b0;
    @(negedge clk);

    // Random traffic over a few hot sets to force hits, conflicts and write-backs
    g_spurious = 1'b1;
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 2))
        0:       idx = 7'h24;
        1:       idx = 7'h11;
        default: idx = 7'($urandom);
      endcase
      a  = {22'($urandom_range(0, 5)), idx, 3'($urandom)};
      wr = 1'($urandom);
      do_op($sformatf("rnd%0d", i), wr, a, 8'($urandom), $urandom_range(0, 2), 1'b0, h, rd, ed);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
